// File: rtl/rv_ctrl_pkg.sv
// Shared encodings and the per-state control word for the multi-cycle RISC-V control FSM.
package rv_ctrl_pkg;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_RTYPE  = 7'b0110011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;

   typedef enum logic [3:0] {
      S_IDLE      = 4'd0,
      S_FETCH     = 4'd1,
      S_DECODE    = 4'd2,
      S_MEM_ADDR  = 4'd3,
      S_MEM_READ  = 4'd4,
      S_MEM_WB    = 4'd5,
      S_MEM_WRITE = 4'd6,
      S_EXEC_R    = 4'd7,
      S_EXEC_I    = 4'd8,
      S_ALU_WB    = 4'd9,
      S_BRANCH    = 4'd10,
      S_JAL       = 4'd11,
      S_TRAP      = 4'd12
   } stateT;

   typedef enum logic [1:0] {ALU_ADD = 2'b00, ALU_SUB = 2'b01, ALU_RTYPE = 2'b10, ALU_ITYPE = 2'b11} aluOpT;
   typedef enum logic [1:0] {SRCB_REG = 2'b00, SRCB_FOUR = 2'b01, SRCB_IMM = 2'b10} srcBT;
   typedef enum logic [1:0] {WB_ALUOUT = 2'b00, WB_MDR = 2'b01, WB_PC = 2'b10} memToRegT;
   typedef enum logic [1:0] {PCSRC_ALU = 2'b00, PCSRC_ALUOUT = 2'b01} pcSourceT;
   typedef enum logic [1:0] {CAUSE_NONE = 2'b00, CAUSE_ILLEGAL = 2'b01, CAUSE_TIMEOUT = 2'b10} trapCauseT;

   typedef struct packed {
      logic     pcWrite;
      logic     pcWriteCond;
      pcSourceT pcSource;
      logic     irWrite;
      logic     iord;
      logic     memRead;
      logic     memWrite;
      memToRegT memToReg;
      logic     regWrite;
      logic     aluSrcA;
      srcBT     aluSrcB;
      aluOpT    aluOp;
      logic     retire;
      logic     trap;
   } ctrlT;

   function automatic logic isWaitState(stateT s);
      return (s == S_FETCH) || (s == S_MEM_READ) || (s == S_MEM_WRITE);
   endfunction

   // Moore control word. FETCH irWrite/pcWrite and MEM_WRITE retire are later gated by mem_ready.
   function automatic ctrlT ctrlFor(stateT s);
      ctrlT c = '0;
      case (s)
         S_FETCH: begin
            c.memRead = 1'b1;
            c.aluSrcB = SRCB_FOUR;
            c.irWrite = 1'b1;
            c.pcWrite = 1'b1;
         end
         S_DECODE:   c.aluSrcB = SRCB_IMM;
         S_MEM_ADDR: begin
            c.aluSrcA = 1'b1;
            c.aluSrcB = SRCB_IMM;
         end
         S_MEM_READ: begin
            c.memRead = 1'b1;
            c.iord    = 1'b1;
         end
         S_MEM_WB: begin
            c.regWrite = 1'b1;
            c.memToReg = WB_MDR;
            c.retire   = 1'b1;
         end
         S_MEM_WRITE: begin
            c.memWrite = 1'b1;
            c.iord     = 1'b1;
            c.retire   = 1'b1;
         end
         S_EXEC_R: begin
            c.aluSrcA = 1'b1;
            c.aluSrcB = SRCB_REG;
            c.aluOp   = ALU_RTYPE;
         end
         S_EXEC_I: begin
            c.aluSrcA = 1'b1;
            c.aluSrcB = SRCB_IMM;
            c.aluOp   = ALU_ITYPE;
         end
         S_ALU_WB: begin
            c.regWrite = 1'b1;
            c.memToReg = WB_ALUOUT;
            c.retire   = 1'b1;
         end
         S_BRANCH: begin
            c.aluSrcA     = 1'b1;
            c.aluSrcB     = SRCB_REG;
            c.aluOp       = ALU_SUB;
            c.pcWriteCond = 1'b1;
            c.pcSource    = PCSRC_ALUOUT;
            c.retire      = 1'b1;
         end
         S_JAL: begin
            c.pcWrite  = 1'b1;
            c.pcSource = PCSRC_ALUOUT;
            c.regWrite = 1'b1;
            c.memToReg = WB_PC;
            c.retire   = 1'b1;
         end
         S_TRAP:  c.trap = 1'b1;
         default: ;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/mc_wait_timer.sv
// Counts stalled cycles in a memory wait state; expired flags the configured limit (0 = never).
module mc_wait_timer #(
   parameter int MEM_TIMEOUT = 15
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   input  logic countEn,
   output logic expired
);

   localparam int W = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);
   localparam logic [W-1:0] LIMIT = W'(MEM_TIMEOUT);

   logic [W-1:0] count;

   // Saturates at the limit so a disabled timer never wraps.
   always_ff @(posedge clk) begin
      if (!rst_n)                         count <= '0;
      else if (clear)                     count <= '0;
      else if (countEn && count != LIMIT) count <= count + W'(1);
   end

   assign expired = (MEM_TIMEOUT != 0) && (count == LIMIT);

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle RISC-V control FSM: sequences fetch/decode/execute/memory/writeback and traps.
module multicycle_control
   import rv_ctrl_pkg::*;
#(
   parameter int MEM_TIMEOUT = 15,
   parameter bit ENABLE_IMM  = 1'b1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [6:0] opcode,
   input  logic       mem_ready,
   output logic       pc_write,
   output logic       pc_write_cond,
   output logic [1:0] pc_source,
   output logic       ir_write,
   output logic       iord,
   output logic       mem_read,
   output logic       mem_write,
   output logic [1:0] mem_to_reg,
   output logic       reg_write,
   output logic       alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [1:0] alu_op,
   output logic       retire,
   output logic       trap,
   output logic [1:0] trap_cause,
   output logic [3:0] state_o
);

   stateT     stateQ, stateNext;
   trapCauseT causeQ, causeNext;
   ctrlT      ctrlQ;
   logic      expired;
   logic      illegal;

   mc_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) uTimer (
      .clk     (clk),
      .rst_n   (rst_n),
      .clear   (stateNext != stateQ),
      .countEn (isWaitState(stateQ) && !mem_ready),
      .expired (expired)
   );

   // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latch).
   always_comb begin
      stateNext = stateQ;
      causeNext = causeQ;
      illegal   = 1'b0;
      case (stateQ)
         S_IDLE:   stateNext = S_FETCH;
         S_FETCH, S_MEM_READ, S_MEM_WRITE: begin
            if (mem_ready) begin
               case (stateQ)
                  S_FETCH:    stateNext = S_DECODE;
                  S_MEM_READ: stateNext = S_MEM_WB;
                  default:    stateNext = S_FETCH;
               endcase
            end else if (expired) begin
               stateNext = S_TRAP;
               causeNext = CAUSE_TIMEOUT;
            end
         end
         S_DECODE: begin
            case (opcode)
               OP_LOAD, OP_STORE: stateNext = S_MEM_ADDR;
               OP_RTYPE:          stateNext = S_EXEC_R;
               OP_BRANCH:         stateNext = S_BRANCH;
               OP_IMM:            if (ENABLE_IMM) stateNext = S_EXEC_I; else illegal = 1'b1;
               OP_JAL:            if (ENABLE_IMM) stateNext = S_JAL;    else illegal = 1'b1;
               default:           illegal = 1'b1;
            endcase
            if (illegal) begin
               stateNext = S_TRAP;
               causeNext = CAUSE_ILLEGAL;
            end
         end
         S_MEM_ADDR: stateNext = (opcode == OP_LOAD) ? S_MEM_READ : S_MEM_WRITE;
         S_EXEC_R, S_EXEC_I: stateNext = S_ALU_WB;
         S_MEM_WB, S_ALU_WB, S_BRANCH, S_JAL: stateNext = S_FETCH;
         S_TRAP:   stateNext = S_TRAP;
         default:  stateNext = S_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments; the control word is registered from
   // the next state so it lines up with the state it describes.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         stateQ <= S_IDLE;
         causeQ <= CAUSE_NONE;
         ctrlQ  <= '0;
      end else begin
         stateQ <= stateNext;
         causeQ <= causeNext;
         ctrlQ  <= ctrlFor(stateNext);
      end
   end

   // irWrite marks FETCH and memWrite marks MEM_WRITE: those strobes complete only with mem_ready.
   assign ir_write      = ctrlQ.irWrite & mem_ready;
   assign pc_write      = ctrlQ.pcWrite & (~ctrlQ.irWrite | mem_ready);
   assign retire        = ctrlQ.retire & (~ctrlQ.memWrite | mem_ready);
   assign pc_write_cond = ctrlQ.pcWriteCond;
   assign pc_source     = ctrlQ.pcSource;
   assign iord          = ctrlQ.iord;
   assign mem_read      = ctrlQ.memRead;
   assign mem_write     = ctrlQ.memWrite;
   assign mem_to_reg    = ctrlQ.memToReg;
   assign reg_write     = ctrlQ.regWrite;
   assign alu_src_a     = ctrlQ.aluSrcA;
   assign alu_src_b     = ctrlQ.aluSrcB;
   assign alu_op        = ctrlQ.aluOp;
   assign trap          = ctrlQ.trap;
   assign trap_cause    = causeQ;
   assign state_o       = stateQ;

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench: per-instruction expected traces built from opcode paths and stall counts.
module tb_multicycle_control;
   import rv_ctrl_pkg::*;

   typedef struct packed {
      logic       pcWrite, pcWriteCond;
      logic [1:0] pcSource;
      logic       irWrite, iord, memRead, memWrite;
      logic [1:0] memToReg;
      logic       regWrite, aluSrcA;
      logic [1:0] aluSrcB, aluOp;
      logic       retire, trap;
      logic [1:0] trapCause;
      logic [3:0] state;
   } obsT;

   typedef struct packed {
      stateT      st;
      logic       mr;
      logic [6:0] op;
      logic [1:0] cause;
   } entryT;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rstA, mrA, rstB, mrB;
   logic [6:0] opA, opB;
   wire        pwA, pwcA, irwA, iordA, mrdA, mwrA, rwA, asaA, retA, trpA;
   wire  [1:0] pcsA, m2rA, asbA, aopA, tcA;
   wire  [3:0] stA;
   wire        pwB, pwcB, irwB, iordB, mrdB, mwrB, rwB, asaB, retB, trpB;
   wire  [1:0] pcsB, m2rB, asbB, aopB, tcB;
   wire  [3:0] stB;
   obsT        obsA, obsB;

   multicycle_control dutA (
      .clk(clk), .rst_n(rstA), .opcode(opA), .mem_ready(mrA),
      .pc_write(pwA), .pc_write_cond(pwcA), .pc_source(pcsA), .ir_write(irwA), .iord(iordA),
      .mem_read(mrdA), .mem_write(mwrA), .mem_to_reg(m2rA), .reg_write(rwA), .alu_src_a(asaA),
      .alu_src_b(asbA), .alu_op(aopA), .retire(retA), .trap(trpA), .trap_cause(tcA), .state_o(stA)
   );

   multicycle_control #(.MEM_TIMEOUT(3), .ENABLE_IMM(1'b0)) dutB (
      .clk(clk), .rst_n(rstB), .opcode(opB), .mem_ready(mrB),
      .pc_write(pwB), .pc_write_cond(pwcB), .pc_source(pcsB), .ir_write(irwB), .iord(iordB),
      .mem_read(mrdB), .mem_write(mwrB), .mem_to_reg(m2rB), .reg_write(rwB), .alu_src_a(asaB),
      .alu_src_b(asbB), .alu_op(aopB), .retire(retB), .trap(trpB), .trap_cause(tcB), .state_o(stB)
   );

   assign obsA = {pwA, pwcA, pcsA, irwA, iordA, mrdA, mwrA, m2rA, rwA, asaA, asbA, aopA, retA, trpA, tcA, stA};
   assign obsB = {pwB, pwcB, pcsB, irwB, iordB, mrdB, mwrB, m2rB, rwB, asaB, asbB, aopB, retB, trpB, tcB, stB};

   int    checks = 0;
   int    errors = 0;
   entryT tr[$];
   logic [6:0] legalOps [6] = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011, 7'b1101111};

   // Expected outputs for one cycle, taken from the per-state output tables.
   function automatic obsT expOut(entryT e);
      obsT o = '0;
      o.state = e.st;
      case (e.st)
         S_FETCH:     begin o.memRead = 1'b1; o.aluSrcB = 2'b01; o.irWrite = e.mr; o.pcWrite = e.mr; end
         S_DECODE:    o.aluSrcB = 2'b10;
         S_MEM_ADDR:  begin o.aluSrcA = 1'b1; o.aluSrcB = 2'b10; end
         S_MEM_READ:  begin o.memRead = 1'b1; o.iord = 1'b1; end
         S_MEM_WB:    begin o.regWrite = 1'b1; o.memToReg = 2'b01; o.retire = 1'b1; end
         S_MEM_WRITE: begin o.memWrite = 1'b1; o.iord = 1'b1; o.retire = e.mr; end
         S_EXEC_R:    begin o.aluSrcA = 1'b1; o.aluSrcB = 2'b00; o.aluOp = 2'b10; end
         S_EXEC_I:    begin o.aluSrcA = 1'b1; o.aluSrcB = 2'b10; o.aluOp = 2'b11; end
         S_ALU_WB:    begin o.regWrite = 1'b1; o.retire = 1'b1; end
         S_BRANCH:    begin o.aluSrcA = 1'b1; o.aluOp = 2'b01; o.pcWriteCond = 1'b1; o.pcSource = 2'b01; o.retire = 1'b1; end
         S_JAL:       begin o.pcWrite = 1'b1; o.pcSource = 2'b01; o.regWrite = 1'b1; o.memToReg = 2'b10; o.retire = 1'b1; end
         S_TRAP:      begin o.trap = 1'b1; o.trapCause = e.cause; end
         default: ;
      endcase
      return o;
   endfunction

   // Opcode is don't-care outside DECODE/MEM_ADDR; FETCH gets a random one to prove that.
   function automatic void pushE(stateT s, logic mr, logic [6:0] op, logic [1:0] cause);
      entryT e;
      e.st = s; e.mr = mr; e.cause = cause;
      e.op = (s == S_FETCH) ? 7'($urandom) : op;
      tr.push_back(e);
   endfunction

   function automatic void pushTrap(logic [1:0] cause);
      repeat (4) pushE(S_TRAP, 1'($urandom), 7'($urandom), cause);
   endfunction

   // A wait state stalls 'stalls' cycles then completes, unless the stall count hits the timeout.
   function automatic bit pushWait(stateT s, int stalls, int tmo, logic [6:0] op);
      for (int i = 0; i < stalls; i++) begin
         pushE(s, 1'b0, op, 2'b00);
         if (tmo != 0 && i == tmo) return 1'b1;
      end
      pushE(s, 1'b1, op, 2'b00);
      return 1'b0;
   endfunction

   function automatic bit pushInstr(logic [6:0] op, bit enImm, int tmo, int fs, int ms);
      bit bad = 1'b0;
      if (pushWait(S_FETCH, fs, tmo, op)) begin pushTrap(2'b10); return 1'b1; end
      pushE(S_DECODE, 1'($urandom), op, 2'b00);
      case (op)
         7'b0000011: begin
            pushE(S_MEM_ADDR, 1'($urandom), op, 2'b00);
            if (pushWait(S_MEM_READ, ms, tmo, op)) begin pushTrap(2'b10); return 1'b1; end
            pushE(S_MEM_WB, 1'($urandom), op, 2'b00);
         end
         7'b0100011: begin
            pushE(S_MEM_ADDR, 1'($urandom), op, 2'b00);
            if (pushWait(S_MEM_WRITE, ms, tmo, op)) begin pushTrap(2'b10); return 1'b1; end
         end
         7'b0110011: begin pushE(S_EXEC_R, 1'($urandom), op, 2'b00); pushE(S_ALU_WB, 1'($urandom), op, 2'b00); end
         7'b0010011: if (enImm) begin
            pushE(S_EXEC_I, 1'($urandom), op, 2'b00); pushE(S_ALU_WB, 1'($urandom), op, 2'b00);
         end else bad = 1'b1;
         7'b1100011: pushE(S_BRANCH, 1'($urandom), op, 2'b00);
         7'b1101111: if (enImm) pushE(S_JAL, 1'($urandom), op, 2'b00); else bad = 1'b1;
         default:    bad = 1'b1;
      endcase
      if (bad) pushTrap(2'b01);
      return bad;
   endfunction

   task automatic step(input bit useB, input logic rstn, input entryT e, output obsT got);
      if (useB) begin rstB = rstn; opB = e.op; mrB = e.mr; end
      else      begin rstA = rstn; opA = e.op; mrA = e.mr; end
      @(negedge clk);
      got = useB ? obsB : obsA;
      @(posedge clk);
      #1;
   endtask

   task automatic doReset(input bit useB);
      obsT   got;
      entryT e = '{S_IDLE, 1'b0, 7'h00, 2'b00};
      step(useB, 1'b0, e, got);
      step(useB, 1'b0, e, got);
   endtask

   task automatic test_reset();
      obsT   got;
      entryT e = '{S_IDLE, 1'b1, 7'b0110011, 2'b00};
      doReset(1'b0);
      step(1'b0, 1'b0, e, got);
      checks++;
      if (got !== expOut(e)) begin errors++; $display("FAIL reset_held got %h want %h", got, expOut(e)); end
      step(1'b0, 1'b1, e, got);
      checks++;
      if (got !== expOut(e)) begin errors++; $display("FAIL reset_release got %h want %h", got, expOut(e)); end
      e.st = S_FETCH;
      step(1'b0, 1'b1, e, got);
      checks++;
      if (got !== expOut(e)) begin errors++; $display("FAIL reset_fetch got %h want %h", got, expOut(e)); end
   endtask

   task automatic test_rtype();
      obsT got;
      doReset(1'b0);
      tr.delete();
      pushE(S_IDLE, 1'b1, 7'h00, 2'b00);
      void'(pushInstr(7'b0110011, 1'b1, 15, 0, 0));
      pushE(S_FETCH, 1'b1, 7'h00, 2'b00);
      foreach (tr[i]) begin
         step(1'b0, 1'b1, tr[i], got);
         checks++;
         if (got !== expOut(tr[i])) begin errors++; $display("FAIL rtype cycle %0d got %h want %h", i, got, expOut(tr[i])); end
      end
   endtask

   task automatic test_ld_slow();
      obsT got;
      int  retireAt = -1;
      doReset(1'b0);
      tr.delete();
      pushE(S_IDLE, 1'b1, 7'h00, 2'b00);
      void'(pushInstr(7'b0000011, 1'b1, 15, 0, 2));
      pushE(S_FETCH, 1'b1, 7'h00, 2'b00);
      foreach (tr[i]) begin
         step(1'b0, 1'b1, tr[i], got);
         if (got.retire && retireAt < 0) retireAt = i;
         checks++;
         if (got !== expOut(tr[i])) begin errors++; $display("FAIL ld_slow cycle %0d got %h want %h", i, got, expOut(tr[i])); end
      end
      checks++;
      if (retireAt !== 7) begin errors++; $display("FAIL ld_latency got %0d want 7", retireAt); end
   endtask

   task automatic test_branch_jal();
      obsT got;
      doReset(1'b0);
      tr.delete();
      pushE(S_IDLE, 1'b1, 7'h00, 2'b00);
      void'(pushInstr(7'b1100011, 1'b1, 15, 0, 0));
      void'(pushInstr(7'b1101111, 1'b1, 15, 0, 0));
      pushE(S_FETCH, 1'b1, 7'h00, 2'b00);
      foreach (tr[i]) begin
         step(1'b0, 1'b1, tr[i], got);
         checks++;
         if (got !== expOut(tr[i])) begin errors++; $display("FAIL br_jal cycle %0d got %h want %h", i, got, expOut(tr[i])); end
         if (tr[i].st == S_JAL) begin
            checks++;
            if ({got.pcWrite, got.regWrite, got.memToReg} !== 4'b1110) begin
               errors++; $display("FAIL jal_strobes got %b want 1110", {got.pcWrite, got.regWrite, got.memToReg});
            end
         end
      end
   endtask

   task automatic test_illegal();
      obsT   got;
      entryT e;
      logic [6:0] badOps [3] = '{7'b1111111, 7'b0010011, 7'b1101111};
      for (int k = 0; k < 3; k++) begin
         bit useB = (k != 0);
         doReset(useB);
         tr.delete();
         pushE(S_IDLE, 1'b1, 7'h00, 2'b00);
         void'(pushInstr(badOps[k], 1'b0, 3, 0, 0));
         foreach (tr[i]) begin
            step(useB, 1'b1, tr[i], got);
            checks++;
            if (got !== expOut(tr[i])) begin errors++; $display("FAIL illegal op %b cycle %0d got %h want %h", badOps[k], i, got, expOut(tr[i])); end
         end
         doReset(useB);
         e = '{S_IDLE, 1'b1, 7'h00, 2'b00};
         step(useB, 1'b1, e, got);
         checks++;
         if (got !== expOut(e)) begin errors++; $display("FAIL trap_reset got %h want %h", got, expOut(e)); end
      end
   endtask

   task automatic test_timeout();
      obsT got;
      int  fetchStalls [2] = '{10, 3};
      for (int k = 0; k < 2; k++) begin
         doReset(1'b1);
         tr.delete();
         pushE(S_IDLE, 1'b1, 7'h00, 2'b00);
         void'(pushInstr(7'b0110011, 1'b0, 3, fetchStalls[k], 0));
         foreach (tr[i]) begin
            step(1'b1, 1'b1, tr[i], got);
            checks++;
            if (got !== expOut(tr[i])) begin errors++; $display("FAIL timeout%0d cycle %0d got %h want %h", k, i, got, expOut(tr[i])); end
         end
      end
   endtask

   task automatic test_reset_mid();
      obsT   got;
      entryT e;
      doReset(1'b0);
      tr.delete();
      pushE(S_IDLE, 1'b1, 7'h00, 2'b00);
      pushE(S_FETCH, 1'b1, 7'h00, 2'b00);
      pushE(S_DECODE, 1'b1, 7'b0100011, 2'b00);
      pushE(S_MEM_ADDR, 1'b1, 7'b0100011, 2'b00);
      pushE(S_MEM_WRITE, 1'b0, 7'b0100011, 2'b00);
      foreach (tr[i]) begin
         step(1'b0, (i == tr.size() - 1) ? 1'b0 : 1'b1, tr[i], got);
         checks++;
         if (got !== expOut(tr[i])) begin errors++; $display("FAIL reset_mid cycle %0d got %h want %h", i, got, expOut(tr[i])); end
      end
      e = '{S_IDLE, 1'b1, 7'b0100011, 2'b00};
      step(1'b0, 1'b1, e, got);
      checks++;
      if (got !== expOut(e)) begin errors++; $display("FAIL reset_mid_idle got %h want %h", got, expOut(e)); end
   endtask

   task automatic test_random();
      obsT got;
      doReset(1'b0);
      tr.delete();
      pushE(S_IDLE, 1'b1, 7'h00, 2'b00);
      for (int n = 0; n < 40; n++) begin
         int fs = $urandom_range(0, 1) ? 0 : int'($urandom_range(1, 3));
         int ms = $urandom_range(0, 1) ? 0 : int'($urandom_range(1, 3));
         void'(pushInstr(legalOps[$urandom_range(0, 5)], 1'b1, 15, fs, ms));
      end
      foreach (tr[i]) begin
         step(1'b0, 1'b1, tr[i], got);
         checks++;
         if (got !== expOut(tr[i])) begin errors++; $display("FAIL random cycle %0d got %h want %h", i, got, expOut(tr[i])); end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      rstA = 1'b0; opA = '0; mrA = 1'b0;
      rstB = 1'b0; opB = '0; mrB = 1'b0;
      @(posedge clk);
      #1;
      test_reset();
      test_rtype();
      test_ld_slow();
      test_branch_jal();
      test_illegal();
      test_timeout();
      test_reset_mid();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
